// File: rtl/axis_ds_pkg.sv
// Shared constants, FSM state type and keep helper for the 512->256 AXIS downsizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_ds_pkg;

  localparam int TDATA_IN_L   = 512;
  localparam int TDATA_OUT_L  = TDATA_IN_L / 2;
  localparam int TUSER_L      = 81;
  localparam int TKEEP_IN_L   = 16;
  localparam int TKEEP_OUT_L  = TKEEP_IN_L / 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } ds_state_t;

  // A legal keep is a run of ones starting at dword 0 (2^n - 1), so keep & (keep + 1) is zero.
  function automatic logic keep_contiguous(input logic [15:0] keep);
    logic [15:0] inc;
    inc = keep + 16'd1;
    return ((keep & inc) == 16'd0);
  endfunction

endpackage

// File: rtl/axis_ds_stats.sv
// Optional statistics counters: completed packets (wrapping) and keep errors (saturating).
// Latency: counters update on the edge that completes the counted handshake.
// Backpressure: none; observes handshakes only.
module axis_ds_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_done_i,
  input  logic        keep_err_i,
  output logic [31:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o
);

  logic [31:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;

  // Packet counter wraps; error counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q <= 32'd0;
      err_cnt_q <= 16'd0;
    end else begin
      if (pkt_done_i) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (keep_err_i && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/axis_512to256_downsizer.sv
// Splits each 512-bit AXIS beat into one or two 256-bit beats; empty upper halves are skipped.
// Latency: beat accepted at edge N is valid on m after edge N (one register stage).
// Backpressure: s_tready opens only when the held beat's last output half is leaving; optional
// counters enabled by defining AXIS_DS_STATS_EN.
module axis_512to256_downsizer
  import axis_ds_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TDATA_IN_L-1:0]  s_tdata,
  input  logic [TKEEP_IN_L-1:0]  s_tkeep,
  input  logic [TUSER_L-1:0]     s_tuser,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [TDATA_OUT_L-1:0] m_tdata,
  output logic [TKEEP_OUT_L-1:0] m_tkeep,
  output logic [TUSER_L-1:0]     m_tuser,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready
`ifdef AXIS_DS_STATS_EN
  ,
  output logic [31:0]            pkt_cnt_o,
  output logic [15:0]            err_cnt_o
`endif
);

  ds_state_t                state_q;
  logic [TDATA_OUT_L-1:0]   m_tdata_q;
  logic [TKEEP_OUT_L-1:0]   m_tkeep_q;
  logic [TUSER_L-1:0]       m_tuser_q;
  logic                     m_tlast_q;
  // Upper half parked while the lower half is on the bus.
  logic [TDATA_OUT_L-1:0]   hi_dat_q;
  logic [TKEEP_OUT_L-1:0]   hi_keep_q;
  logic                     last_q;
  logic                     hi_used_q;

  logic hi_used_d;
  logic s_hs;
  logic m_hs;

  assign hi_used_d = |s_tkeep[TKEEP_IN_L-1:TKEEP_OUT_L];
  // The register frees when empty, or when the final half of the held beat is being taken.
  assign s_tready  = (state_q == EMPTY) |
                     (m_tready & ((state_q == HI) | ((state_q == LO) & ~hi_used_q)));
  assign s_hs      = s_tvalid & s_tready;
  assign m_hs      = m_tvalid & m_tready;

  // FSM: load on input handshake, swap in upper half after LO, drop to EMPTY when drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      m_tdata_q <= '0;
      m_tkeep_q <= '0;
      m_tuser_q <= '0;
      m_tlast_q <= 1'b0;
      hi_dat_q  <= '0;
      hi_keep_q <= '0;
      last_q    <= 1'b0;
      hi_used_q <= 1'b0;
    end else if (s_hs) begin
      state_q   <= LO;
      m_tdata_q <= s_tdata[TDATA_OUT_L-1:0];
      m_tkeep_q <= s_tkeep[TKEEP_OUT_L-1:0];
      m_tuser_q <= s_tuser;
      m_tlast_q <= s_tlast & ~hi_used_d;
      hi_dat_q  <= s_tdata[TDATA_IN_L-1:TDATA_OUT_L];
      hi_keep_q <= s_tkeep[TKEEP_IN_L-1:TKEEP_OUT_L];
      last_q    <= s_tlast;
      hi_used_q <= hi_used_d;
    end else if ((state_q == LO) && m_tready && hi_used_q) begin
      state_q   <= HI;
      m_tdata_q <= hi_dat_q;
      m_tkeep_q <= hi_keep_q;
      m_tlast_q <= last_q;
    end else if ((state_q != EMPTY) && s_tready) begin
      state_q   <= EMPTY;
    end
  end

  assign m_tvalid = (state_q != EMPTY);
  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tuser  = m_tuser_q;
  assign m_tlast  = m_tlast_q;

`ifdef AXIS_DS_STATS_EN
  axis_ds_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt_done_i (m_hs & m_tlast),
    .keep_err_i (s_hs & ~keep_contiguous(s_tkeep)),
    .pkt_cnt_o  (pkt_cnt_o),
    .err_cnt_o  (err_cnt_o)
  );
`else
  logic unused_m_hs;
  assign unused_m_hs = m_hs;
`endif

endmodule

// File: tb/tb_axis_512to256_downsizer.sv
// Randomised + directed bench for the 512->256 downsizer with a queue-based reference model.
// Latency: n/a.
// Backpressure: m_tready driven in always-on, toggling, random or manual modes.
module tb_axis_512to256_downsizer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] s_tdata = '0;
  logic [15:0]  s_tkeep = '0;
  logic [80:0]  s_tuser = '0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic [7:0]   m_tkeep;
  logic [80:0]  m_tuser;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
`ifdef AXIS_DS_STATS_EN
  logic [31:0]  pkt_cnt_o;
  logic [15:0]  err_cnt_o;
`endif

  axis_512to256_downsizer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tuser  (s_tuser),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
`ifdef AXIS_DS_STATS_EN
    ,
    .pkt_cnt_o(pkt_cnt_o),
    .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] d;
    logic [7:0]   k;
    logic [80:0]  u;
    logic         l;
  } beat_t;

  beat_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          out_beats = 0;
  logic [7:0]  last_keep = '0;
  logic [31:0] pkt_m = '0;
  logic [15:0] err_m = '0;
  int          rmode = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] r512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [80:0] r81();
    logic [95:0] v;
    v = {$urandom, $urandom, $urandom};
    return v[80:0];
  endfunction

  // Reference: every accepted 512-bit beat becomes one or two expected 256-bit beats.
  always @(negedge clk) begin
    beat_t hd;
    if (!rst_n) begin
      exp_q.delete();
      pkt_m = '0;
      err_m = '0;
    end else begin
      chk("m_tvalid", 256'(m_tvalid), 256'(exp_q.size() > 0));
      chk("s_tready", 256'(s_tready),
          256'((exp_q.size() == 0) || (m_tready && exp_q.size() == 1)));
`ifdef AXIS_DS_STATS_EN
      chk("pkt_cnt", 256'(pkt_cnt_o), 256'(pkt_m));
      chk("err_cnt", 256'(err_cnt_o), 256'(err_m));
`endif
      if (m_tvalid && exp_q.size() > 0) begin
        hd = exp_q[0];
        chk("m_tdata", m_tdata, hd.d);
        chk("m_tkeep", 256'(m_tkeep), 256'(hd.k));
        chk("m_tuser", 256'(m_tuser), 256'(hd.u));
        chk("m_tlast", 256'(m_tlast), 256'(hd.l));
        if (m_tready) begin
          void'(exp_q.pop_front());
          out_beats++;
          last_keep = hd.k;
          if (hd.l) pkt_m = pkt_m + 32'd1;
        end
      end
      if (s_tvalid && s_tready) begin
        logic hi;
        hi = (s_tkeep[15:8] != 8'h00);
        exp_q.push_back('{d: s_tdata[255:0], k: s_tkeep[7:0], u: s_tuser, l: s_tlast & ~hi});
        if (hi) exp_q.push_back('{d: s_tdata[511:256], k: s_tkeep[15:8], u: s_tuser, l: s_tlast});
        // Legal keep is 2^n-1: adding one clears every set bit.
        if (((s_tkeep + 16'd1) & s_tkeep) != 16'd0 && err_m != 16'hFFFF) err_m = err_m + 16'd1;
      end
    end
  end

  // Sink readiness pattern, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        2: m_tready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [511:0] d, input logic [15:0] k, input logic [80:0] u,
                      input logic l);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) begin
      total++; bad++;
      $display("FAIL send_timeout: got s_tready=0 want 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_tvalid = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [511:0] d;
    logic [80:0]  u;
    logic [15:0]  k;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_tvalid", 256'(m_tvalid), 256'(0));
    chk("rst_tready", 256'(s_tready), 256'(1));
    chk("rst_tdata", m_tdata, 256'(0));
    chk("rst_tkeep", 256'(m_tkeep), 256'(0));
    chk("rst_tlast", 256'(m_tlast), 256'(0));
    chk("rst_tuser", 256'(m_tuser), 256'(0));
    @(posedge clk);
    #1;

    // Full beat split in two.
    d = r512();
    d[31:0] = 32'hA0A00000;
    d[287:256] = 32'hB1B10000;
    send(d, 16'hFFFF, r81(), 1'b1);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("full_b1_keep", 256'(m_tkeep), 256'(8'hFF));
    chk("full_b1_last", 256'(m_tlast), 256'(0));
    chk("full_b1_dw0", 256'(m_tdata[31:0]), 256'(32'hA0A00000));
    chk("full_b1_rdy", 256'(s_tready), 256'(0));
    @(negedge clk);
    chk("full_b2_keep", 256'(m_tkeep), 256'(8'hFF));
    chk("full_b2_last", 256'(m_tlast), 256'(1));
    chk("full_b2_dw0", 256'(m_tdata[31:0]), 256'(32'hB1B10000));
    drain();

    // Short last beat: one output beat.
    out_beats = 0;
    send(r512(), 16'h00FF, r81(), 1'b1);
    drain();
    chk("short_beats", 256'(out_beats), 256'(1));
    chk("short_keep", 256'(last_keep), 256'(8'hFF));

    // Back-to-back narrow beats at full rate.
    for (int i = 0; i < 4; i++) begin
      s_tdata = r512(); s_tkeep = 16'h000F; s_tuser = r81(); s_tlast = (i == 3);
      s_tvalid = 1'b1;
      @(negedge clk);
      chk("b2b_rdy", 256'(s_tready), 256'(1));
      if (i > 0) chk("b2b_vld", 256'(m_tvalid), 256'(1));
      @(posedge clk);
      #1;
    end
    drain();

    // Three-beat packet under toggling backpressure.
    out_beats = 0;
    rmode = 1;
    u = r81();
    send(r512(), 16'hFFFF, u, 1'b0);
    send(r512(), 16'hFFFF, u, 1'b0);
    send(r512(), 16'h003F, u, 1'b1);
    drain();
    chk("tog_beats", 256'(out_beats), 256'(5));
    chk("tog_lastkeep", 256'(last_keep), 256'(8'h3F));

    // Reset while the upper half is on the bus.
    rmode = 3;
    m_tready = 1'b0;
    send(r512(), 16'hFFFF, r81(), 1'b1);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    @(negedge clk);
    chk("hi_before_rst", 256'(m_tlast), 256'(1));
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    chk("post_rst_vld", 256'(m_tvalid), 256'(0));
    chk("post_rst_rdy", 256'(s_tready), 256'(1));
    rmode = 0;
    @(posedge clk);
    #1;
    send(r512(), 16'h0FFF, r81(), 1'b1);
    drain();

    // Three packets, one with a hole in keep.
    pulse_reset();
    rmode = 2;
    send(r512(), 16'hFFFF, r81(), 1'b0);
    send(r512(), 16'h00F0, r81(), 1'b1);
    send(r512(), 16'h00FF, r81(), 1'b1);
    send(r512(), 16'h0000, r81(), 1'b1);
    drain();
`ifdef AXIS_DS_STATS_EN
    chk("stats_pkt", 256'(pkt_cnt_o), 256'(3));
    chk("stats_err", 256'(err_cnt_o), 256'(1));
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: k = 16'hFFFF >> $urandom_range(0, 16);
        1: k = 16'hFFFF;
        2: k = 16'($urandom);
        default: k = 16'h00FF >> $urandom_range(0, 8);
      endcase
      send(r512(), k, r81(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
